// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder-tree accumulation datapath.
package adder_tree_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int LAYER_DEF        = 2;
  localparam int ACC_WIDTH_DEF    = 48;
  localparam int RESULT_DEPTH_DEF = 2;
  localparam int BEAT_WIDTH_DEF   = 16;

  // One finished group in the default configuration.
  typedef struct packed {
    logic [ACC_WIDTH_DEF-1:0]  acc;
    logic [BEAT_WIDTH_DEF-1:0] beats;
  } result_t;

  // Number of tree input lanes for a given depth.
  function automatic int lanes(input int layer);
    return 1 << layer;
  endfunction

endpackage

// File: rtl/adder_tree.sv
// Pipelined binary adder tree: LAYER register stages, one per tree level.
// Node i sums children 2i and 2i+1; indices >= LANES are the input lanes.
module AdderTree
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LAYER      = LAYER_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [lanes(LAYER)*DATA_WIDTH-1:0]   in_data,
  output logic [DATA_WIDTH-1:0]                out_sum
);

  localparam int LANES = lanes(LAYER);

  logic [DATA_WIDTH-1:0] node [1:LANES-1];

  for (genvar gi = 1; gi < LANES; gi++) begin : g_node
    if (2 * gi >= LANES) begin : g_leaf
      // Bottom level: add a pair of input lanes.
      always_ff @(posedge clk) begin
        if (rst) node[gi] <= '0;
        else     node[gi] <= in_data[(2*gi-LANES)*DATA_WIDTH +: DATA_WIDTH]
                           + in_data[(2*gi+1-LANES)*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin : g_inner
      // Upper levels: add the two child nodes.
      always_ff @(posedge clk) begin
        if (rst) node[gi] <= '0;
        else     node[gi] <= node[2*gi] + node[2*gi+1];
      end
    end
  end

  assign out_sum = node[1];

endmodule

// File: rtl/result_fifo.sv
// Synchronous FIFO for finished group results. A push into a full FIFO or a
// pop from an empty one is ignored.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is data only; validity comes from the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/adder_tree_sequencer.sv
// Accumulates adder-tree sums of input beats into per-group results.
// in_ready is throttled by a pending-result count that covers both groups
// still in the tree pipeline and results waiting in the FIFO, so a push
// can never land on a full FIFO.
module adder_tree_sequencer
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int LAYER        = LAYER_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int RESULT_DEPTH = RESULT_DEPTH_DEF,
  parameter int BEAT_WIDTH   = BEAT_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [lanes(LAYER)*DATA_WIDTH-1:0] in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_WIDTH-1:0]               out_data,
  output logic [BEAT_WIDTH-1:0]              out_beats,
  output logic                               busy
);

  localparam int PEND_W = $clog2(RESULT_DEPTH + 1);
  localparam int RES_W  = ACC_WIDTH + BEAT_WIDTH;
  localparam logic [BEAT_WIDTH-1:0] BEATS_MAX = '1;

  logic                         accept, pend_inc, pop, push;
  logic [LAYER-1:0]             tag_valid, tag_last;
  logic                         exit_valid, exit_last;
  logic [DATA_WIDTH-1:0]        tree_sum;
  logic signed [DATA_WIDTH-1:0] tree_sum_s;
  logic [ACC_WIDTH-1:0]         sum_ext, acc, acc_next;
  logic [BEAT_WIDTH-1:0]        beats, beats_next;
  logic [PEND_W-1:0]            pending;
  logic                         open_grp;
  logic [RES_W-1:0]             push_data, head;
  logic                         fifo_empty;

  AdderTree #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAYER      (LAYER)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .out_sum (tree_sum)
  );

  assign accept     = in_valid && in_ready;
  assign pend_inc   = accept && in_last;
  assign exit_valid = tag_valid[LAYER-1];
  assign exit_last  = tag_last[LAYER-1];

  assign tree_sum_s = tree_sum;
  assign sum_ext    = ACC_WIDTH'(tree_sum_s);
  assign acc_next   = acc + sum_ext;
  assign beats_next = (beats == BEATS_MAX) ? beats : beats + BEAT_WIDTH'(1);

  assign push      = exit_valid && exit_last;
  assign push_data = {acc_next, beats_next};
  assign pop       = out_valid && out_ready;

  // Tag pipeline tracks each beat alongside its partial sums in the tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_last  <= '0;
    end else begin
      tag_valid[0] <= accept;
      tag_last[0]  <= in_last;
      for (int i = 1; i < LAYER; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
    end
  end

  // Accumulate tree sums as their tags exit; a last tag closes the group.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      beats <= '0;
    end else if (exit_valid) begin
      if (exit_last) begin
        acc   <= '0;
        beats <= '0;
      end else begin
        acc   <= acc_next;
        beats <= beats_next;
      end
    end
  end

  // Pending results: counted from acceptance of a last beat until popped.
  always_ff @(posedge clk) begin
    if (rst)                   pending <= '0;
    else if (pend_inc && !pop) pending <= pending + PEND_W'(1);
    else if (!pend_inc && pop) pending <= pending - PEND_W'(1);
  end

  // Input-side open-group flag, used only for busy.
  always_ff @(posedge clk) begin
    if (rst)         open_grp <= 1'b0;
    else if (accept) open_grp <= !in_last;
  end

  result_fifo #(
    .DEPTH (RESULT_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign in_ready  = (pending < PEND_W'(RESULT_DEPTH));
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : head[RES_W-1:BEAT_WIDTH];
  assign out_beats = fifo_empty ? '0 : head[BEAT_WIDTH-1:0];
  assign busy      = (pending != '0) || open_grp;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Bench for adder_tree_sequencer: scoreboard of expected group results,
// plus a small second instance for beat-counter saturation and narrow wrap.
module tb_adder_tree_sequencer;
  import adder_tree_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [47:0]  out_data;
  logic [15:0]  out_beats;

  logic         s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b1;
  logic [15:0]  s_in_data = '0;
  logic         s_in_ready, s_out_valid, s_busy;
  logic [11:0]  s_out_data;
  logic [1:0]   s_out_beats;

  adder_tree_sequencer #(
    .DATA_WIDTH(32), .LAYER(2), .ACC_WIDTH(48), .RESULT_DEPTH(2), .BEAT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats), .busy(busy)
  );

  adder_tree_sequencer #(
    .DATA_WIDTH(8), .LAYER(1), .ACC_WIDTH(12), .RESULT_DEPTH(2), .BEAT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_beats(s_out_beats), .busy(s_busy)
  );

  int          errors = 0;
  int          checks = 0;
  result_t     q[$];
  logic [47:0] m_acc = '0;
  logic [15:0] m_beats = '0;

  function automatic logic [127:0] rep(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [47:0] lane_sum_ext(input logic [127:0] d);
    logic [31:0] s;
    s = d[31:0] + d[63:32] + d[95:64] + d[127:96];
    return {{16{s[31]}}, s};
  endfunction

  task automatic model_beat(input logic [127:0] d, input bit last);
    result_t r;
    m_acc   = m_acc + lane_sum_ext(d);
    m_beats = m_beats + 16'd1;
    if (last) begin
      r.acc   = m_acc;
      r.beats = m_beats;
      q.push_back(r);
      m_acc   = '0;
      m_beats = '0;
    end
  endtask

  // Entered and left at posedge+1; returns just after the accepting edge.
  task automatic send_beat(input logic [127:0] d, input bit last);
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    model_beat(d, last);
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: outstanding=%0d out_valid=%0b required 0/0", q.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard compare on every pop and hold-stability while stalled.
  logic        hold_v = 1'b0;
  logic [47:0] hold_d;
  logic [15:0] hold_b;
  result_t     exp_r;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_beats !== hold_b) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%h beats=%0d required 1/%h/%0d",
                   out_valid, out_data, out_beats, hold_d, hold_b);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_b = out_beats;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: data=%h beats=%0d required none", out_data, out_beats);
        end else begin
          exp_r = q.pop_front();
          if (out_data !== exp_r.acc || out_beats !== exp_r.beats) begin
            errors++;
            $display("FAIL result: data=%h beats=%0d required %h/%0d",
                     out_data, out_beats, exp_r.acc, exp_r.beats);
          end
        end
      end
    end
  end

  task automatic test_reset();
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
          out_beats !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%0b v=%0b d=%h b=%0d busy=%0b required 1/0/0/0/0",
                 in_ready, out_valid, out_data, out_beats, busy);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: rdy=%0b v=%0b busy=%0b required 1/0/0", in_ready, out_valid, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    logic exp_v[3];
    exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_v[2] = 1'b1;
    out_ready = 1'b1;
    send_beat({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== exp_v[i]) begin
        errors++;
        $display("FAIL latency_e%0d: out_valid=%0b required %0b", i, out_valid, exp_v[i]);
      end
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send_beat(rep(32'd1), 1'b0);
    send_beat(rep(32'd2), 1'b0);
    send_beat(rep(32'd3), 1'b1);
    wait_drain();
  endtask

  task automatic test_idle_gaps();
    for (int i = 1; i <= 3; i++) begin
      send_beat(rep(32'(i)), i == 3);
      repeat (2) @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_negative();
    send_beat(rep(32'hFFFF_FFFF), 1'b0);
    send_beat(rep(32'hFFFF_FFFF), 1'b1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(rep(32'd1), 1'b1);
    send_beat(rep(32'd2), 1'b1);
    in_valid = 1'b1; in_data = rep(32'd3); in_last = 1'b1;
    model_beat(rep(32'd3), 1'b1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready_low: in_ready=%0b required 0", in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_before_pop: in_ready=%0b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_first_pop: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_coincide: in_ready=%0b busy=%0b required 1/1", in_ready, busy);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_reset_mid_group();
    out_ready = 1'b1;
    send_beat(rep(32'd5), 1'b0);
    send_beat(rep(32'd5), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0; m_beats = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%0b rdy=%0b v=%0b required 0/1/0", busy, in_ready, out_valid);
    end
    @(posedge clk); #1;
    send_beat(rep(32'd1), 1'b1);
    wait_drain();
  endtask

  task automatic test_pop_coincide();
    int budget;
    out_ready = 1'b0;
    send_beat(rep(32'd7), 1'b1);
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pc_wait_valid: out_valid=%0b required 1", out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = rep(32'd9); in_last = 1'b1;
    model_beat(rep(32'd9), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pc_pending_one: in_ready=%0b busy=%0b required 1/1", in_ready, busy);
    end
    @(posedge clk); #1;
    send_beat(rep(32'd11), 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pc_pending_two: in_ready=%0b required 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pc_idle: busy=%0b in_ready=%0b required 0/1", busy, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int len;
    out_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) begin
        send_beat({$urandom, $urandom, $urandom, $urandom}, b == len - 1);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    wait_drain();
  endtask

  // Narrow instance: 2 lanes of 8 bits, 12-bit acc, 2-bit beat counter.
  task automatic sat_group(input logic [15:0] d, input int nbeats,
                           input logic [11:0] exp_d, input logic [1:0] exp_b, input string name);
    int budget;
    for (int i = 0; i < nbeats; i++) begin
      s_in_valid = 1'b1; s_in_data = d; s_in_last = (i == nbeats - 1);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    budget = 0;
    @(negedge clk);
    while (!s_out_valid && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== exp_d || s_out_beats !== exp_b) begin
      errors++;
      $display("FAIL %s: v=%0b data=%h beats=%0d required 1/%h/%0d",
               name, s_out_valid, s_out_data, s_out_beats, exp_d, exp_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_beat_saturation();
    s_out_ready = 1'b1;
    sat_group(16'h0001, 5, 12'd5, 2'd3, "sat_beats");
    sat_group(16'h8080, 1, 12'h000, 2'd1, "narrow_wrap");
    sat_group(16'h00FF, 2, 12'hFFE, 2'd2, "narrow_sign_ext");
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_idle_gaps();
    test_negative();
    test_backpressure();
    test_reset_mid_group();
    test_pop_coincide();
    test_random();
    test_beat_saturation();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: outstanding=%0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_tree_sequencer.md
ADDER_TREE_SEQUENCER -- requirements
Module: adder_tree_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: lane and tree-sum width.
REQ-002 SHALL have parameter LAYER, default 2: tree depth; LANES = 2^LAYER; tree latency = LAYER register stages.
REQ-003 SHALL have parameter ACC_WIDTH, default 48: accumulator and result width, ACC_WIDTH >= DATA_WIDTH.
REQ-004 SHALL have parameter RESULT_DEPTH, default 2: result FIFO depth, >= 1.
REQ-005 SHALL have parameter BEAT_WIDTH, default 16: beats-per-group counter width.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1: input beat valid.
REQ-009 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready at an edge.
REQ-010 SHALL have port in_data, input, LANES*DATA_WIDTH: packed lane vector, lane 0 in the LSBs.
REQ-011 SHALL have port in_last, input, 1: beat closes the current group.
REQ-012 SHALL have port out_valid, output, 1: result available.
REQ-013 SHALL have port out_ready, input, 1: result popped when out_valid && out_ready.
REQ-014 SHALL have port out_data, output, ACC_WIDTH: group sum.
REQ-015 SHALL have port out_beats, output, BEAT_WIDTH: beat count of the group.
REQ-016 SHALL have port busy, output, 1: high while any group is open, in flight or unpopped.

Function
REQ-017 SHALL drive in_data unmodified into an internal adder tree every cycle, with a LAYER-deep valid/last tag shift register loaded with (in_valid && in_ready, in_last).
REQ-018 SHALL add a tree sum into the accumulator at the edge where its tag exits the shift register, LAYER edges after the acceptance edge E; tag-invalid cycles leave the accumulator unchanged.
REQ-019 SHALL sign-extend the DATA_WIDTH tree sum (wrapping mod 2^DATA_WIDTH) to ACC_WIDTH; accumulation wraps mod 2^ACC_WIDTH; no overflow flag.
REQ-020 SHALL, at a last-tagged exit edge, push {acc + sum, beats + 1} into the result FIFO and clear acc and beats to 0 at that same edge.
REQ-021 SHALL make a single-beat group's result visible (out_valid high) in the cycle after edge E+LAYER.
REQ-022 SHALL saturate the beat counter at 2^BEAT_WIDTH-1.
REQ-023 SHALL keep a registered pending counter: +1 on an accepted last beat, -1 on a pop, unchanged when both occur at the same edge.
REQ-024 SHALL drive in_ready = (pending < RESULT_DEPTH), a function of registered state only (no combinational path from in_valid, in_last or out_ready).
REQ-025 SHALL guarantee by REQ-024 that a FIFO push never finds the FIFO full; no result is ever dropped.
REQ-026 SHALL drive out_valid = FIFO not empty, with out_data/out_beats taken from the FIFO head; results SHALL be delivered in order.
REQ-027 SHALL allow idle gaps (in_valid low) inside a group without affecting the sum.
REQ-028 SHALL hold out_data/out_beats stable while out_valid && !out_ready.
REQ-029 SHALL drive busy = (pending != 0) || open group accepted on the input side without last.

Reset
REQ-030 SHALL, with rst high at an edge, clear tag pipeline, accumulator, beat counter, pending, FIFO pointers and open-group flag; tree registers are reset at the same edge.
REQ-031 SHALL hold outputs during and after reset at in_ready=1, out_valid=0, out_data=0, out_beats=0, busy=0.
REQ-032 SHALL discard a partially accumulated or in-flight group on a reset mid-operation; no stale value reaches a later result.

Structure
REQ-033 SHALL take lane-count helper, default parameters and result struct {acc, beats} from shared package adder_tree_pkg.
REQ-034 SHALL instantiate the team's existing AdderTree module (DATA_WIDTH, LAYER) as the datapath.
REQ-035 SHALL implement the FIFO as the single new sub-module result_fifo (synchronous, parameterised depth and width).

Verification (LAYER=2, DATA_WIDTH=32, ACC_WIDTH=48, RESULT_DEPTH=2)
REQ-036 SHALL cover a single beat {1,2,3,4} with last accepted at edge 0 -> out_valid after edge 2, out_data=10, out_beats=1.
REQ-037 SHALL cover back-to-back beats {1,1,1,1}, {2,2,2,2}, {3,3,3,3} (last on the third) -> out_data=24, out_beats=3; a repeat with two idle cycles between beats gives the same result.
REQ-038 SHALL cover a group of all lanes 0xFFFFFFFF, two beats -> out_data=0xFFFF_FFFF_FFF8 (-8), out_beats=2.
REQ-039 SHALL cover out_ready=0 with three single-beat groups {1..}, {2..}, {3..} offered -> two accepted, in_ready=0; then out_ready=1 -> sums 4, 8, 12 in order; in_ready rises the cycle after the first pop.
REQ-040 SHALL cover two non-last beats {5,5,5,5}, then rst for 1 cycle, then {1,1,1,1} with last -> out_data=4, out_beats=1; busy=0 right after reset.
REQ-041 SHALL cover pending=2 with a pop coinciding with acceptance of a last beat when pending=1 -> pending stays 1 and no FIFO overflow occurs.
